// File: rtl/space_wire_tick_arbiter_if.sv
// Time-code transmit handshake between the tick arbiter (master) and the
// SpaceWire transmitter (slave).
`timescale 1ns/1ps
interface space_wire_tick_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TIME_W  = 8
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic              o_tx_valid;
    logic [TIME_W-1:0] o_tx_time;
    logic [SRC_W-1:0]  o_tx_src;
    logic              i_tx_ready;

    modport master (output o_tx_valid, output o_tx_time, output o_tx_src, input i_tx_ready);
    modport slave  (input o_tx_valid, input o_tx_time, input o_tx_src, output i_tx_ready);
endinterface

// File: rtl/space_wire_tick_arbiter.sv
// Round-robin arbiter sharing one SpaceWire time-code transmitter among NUM_REQ tick sources,
// with a forced idle gap after each time-code. SPACE_WIRE_TICK_ARB_DROP_CNT_EN adds drop counters.
`timescale 1ns/1ps
module space_wire_tick_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TIME_W     = 8,
    parameter int GAP_CYCLES = 16,
    parameter int DROP_CNT_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_pulse,
    input  logic [NUM_REQ*TIME_W-1:0] i_req_time,
    space_wire_tick_arbiter_if.master tx,
    output logic [NUM_REQ-1:0]        o_pending,
    output logic                      o_busy
`ifdef SPACE_WIRE_TICK_ARB_DROP_CNT_EN
    ,
    input  logic                          i_drop_clr,
    output logic [NUM_REQ*DROP_CNT_W-1:0] o_drop_cnt
`endif
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [TIME_W-1:0]  slot_q [NUM_REQ];
    logic [TIME_W-1:0]  slot_d [NUM_REQ];
    logic               tx_valid_q, tx_valid_d;
    logic [TIME_W-1:0]  tx_time_q, tx_time_d;
    logic [SRC_W-1:0]   tx_src_q, tx_src_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               rearm_q, rearm_d;

    logic               found;
    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   idx;
    logic               xfer;

    assign xfer = (state_q == OFFER) && tx_valid_q && tx.i_tx_ready;

    // Search starts just after the last granted index and wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = SRC_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pending_d  = pending_q | i_req_pulse;
        tx_valid_d = tx_valid_q;
        tx_time_d  = tx_time_q;
        tx_src_d   = tx_src_q;
        gap_d      = gap_q;
        rearm_d    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot_d[k] = i_req_pulse[k] ? i_req_time[k*TIME_W +: TIME_W] : slot_q[k];
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = OFFER;
                    ptr_d      = win;
                    tx_valid_d = 1'b1;
                    tx_time_d  = slot_q[win];
                    tx_src_d   = win;
                end
            end
            OFFER: begin
                // A pulse from the offered source during the offer is a fresh tick that must survive the transfer.
                if (xfer) begin
                    tx_valid_d          = 1'b0;
                    pending_d[tx_src_q] = rearm_q | i_req_pulse[tx_src_q];
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rearm_d = rearm_q | i_req_pulse[tx_src_q];
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            ptr_q      <= SRC_W'(NUM_REQ - 1);
            pending_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_time_q  <= '0;
            tx_src_q   <= '0;
            gap_q      <= '0;
            rearm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
            tx_valid_q <= tx_valid_d;
            tx_time_q  <= tx_time_d;
            tx_src_q   <= tx_src_d;
            gap_q      <= gap_d;
            rearm_q    <= rearm_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            slot_q[k] <= slot_d[k];
        end
    end

    assign tx.o_tx_valid = tx_valid_q;
    assign tx.o_tx_time  = tx_time_q;
    assign tx.o_tx_src   = tx_src_q;
    assign o_pending     = pending_q;
    assign o_busy        = (state_q != IDLE);

`ifdef SPACE_WIRE_TICK_ARB_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q [NUM_REQ];
    logic [DROP_CNT_W-1:0] drop_d [NUM_REQ];
    logic [NUM_REQ-1:0]    drop_ev;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    // An overwrite of a still-pending tick loses the older one, except the first re-arm of the offered source.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            drop_ev[k] = i_req_pulse[k] && pending_q[k] &&
                         !((state_q == OFFER) && (tx_src_q == SRC_W'(k)) && !rearm_q);
            drop_d[k]  = drop_q[k];
            if (i_drop_clr) begin
                drop_d[k] = '0;
            end else if (drop_ev[k]) begin
                drop_d[k] = sat_inc(drop_q[k]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_reset) begin
                drop_q[k] <= '0;
            end else begin
                drop_q[k] <= drop_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            o_drop_cnt[k*DROP_CNT_W +: DROP_CNT_W] = drop_q[k];
        end
    end
`else
    // Overwrites still replace the slot; they are simply not counted.
`endif

endmodule

// File: tb/tb_space_wire_tick_arbiter.sv
// Self-checking bench for space_wire_tick_arbiter: vector table plus hand-written corner sequences,
// transfers checked against a queue of expected (src, time) pairs.
`timescale 1ns/1ps
module tb_space_wire_tick_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIME_W  = 8;
    localparam int GAP     = 16;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] t;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] times;
        int          n;
        logic [7:0]  order;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_req_pulse;
    logic [31:0] i_req_time;
    logic [3:0]  o_pending;
    logic        o_busy;
`ifdef SPACE_WIRE_TICK_ARB_DROP_CNT_EN
    logic        i_drop_clr;
    logic [31:0] o_drop_cnt;
`endif

    space_wire_tick_arbiter_if #(.NUM_REQ(NUM_REQ), .TIME_W(TIME_W)) bus ();

    space_wire_tick_arbiter #(
        .NUM_REQ(NUM_REQ), .TIME_W(TIME_W), .GAP_CYCLES(GAP), .DROP_CNT_W(8)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_req_pulse(i_req_pulse),
        .i_req_time(i_req_time),
        .tx(bus),
        .o_pending(o_pending),
        .o_busy(o_busy)
`ifdef SPACE_WIRE_TICK_ARB_DROP_CNT_EN
        ,
        .i_drop_clr(i_drop_clr),
        .o_drop_cnt(o_drop_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_xfer = -1;
    exp_t exp_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int s, input logic [7:0] t);
        exp_t e;
        e.src = 2'(s);
        e.t   = t;
        exp_q.push_back(e);
    endtask

    // Transfers are observed on the falling edge before the edge that completes them.
    task automatic tick();
        exp_t e;
        @(negedge i_clk);
        if (i_reset) begin
            last_xfer = -1;
        end else if (bus.o_tx_valid && bus.i_tx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_xfer: got src=%0d time=%02h, required no transfer",
                         bus.o_tx_src, bus.o_tx_time);
            end else begin
                e = exp_q.pop_front();
                check("xfer_src", 32'(bus.o_tx_src), 32'(e.src));
                check("xfer_time", 32'(bus.o_tx_time), 32'(e.t));
            end
            if (last_xfer >= 0) check("xfer_spacing", 32'(cyc - last_xfer), 32'(GAP + 2));
            last_xfer = cyc;
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_req_pulse = '0;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d transfers outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (GAP + 3) tick();
        check({name, "_busy_idle"}, 32'(o_busy), 32'd0);
        check({name, "_pending_idle"}, 32'(o_pending), 32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mask: 4'b0001, times: 32'h0000_0005, n: 1, order: 8'h00};
        vecs[1] = '{mask: 4'b1111, times: 32'h1312_1110, n: 4, order: 8'hE4};
        vecs[2] = '{mask: 4'b1010, times: 32'hA0B0_C0D0, n: 2, order: 8'h0D};
        vecs[3] = '{mask: 4'b1100, times: 32'h7F44_55AA, n: 2, order: 8'h0E};
        vecs[4] = '{mask: 4'b1000, times: 32'hC100_0000, n: 1, order: 8'h03};
        vecs[5] = '{mask: 4'b0110, times: 32'h00FF_0100, n: 2, order: 8'h09};

        i_reset         = 1'b1;
        i_req_pulse     = '0;
        i_req_time      = '0;
        bus.i_tx_ready  = 1'b1;
`ifdef SPACE_WIRE_TICK_ARB_DROP_CNT_EN
        i_drop_clr = 1'b0;
`endif
        tick();
        tick();
        check("rst_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rst_time", 32'(bus.o_tx_time), 32'd0);
        check("rst_src", 32'(bus.o_tx_src), 32'd0);
        check("rst_pending", 32'(o_pending), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        tick();
        check("rel_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rel_busy", 32'(o_busy), 32'd0);

        // Single tick: latency and handshake.
        do_reset();
        i_req_pulse = 4'b0001;
        i_req_time  = 32'h0000_0005;
        push(0, 8'h05);
        tick();
        i_req_pulse = '0;
        check("t1_pending", 32'(o_pending), 32'h1);
        check("t1_valid_early", 32'(bus.o_tx_valid), 32'd0);
        tick();
        check("t1_valid", 32'(bus.o_tx_valid), 32'd1);
        check("t1_time", 32'(bus.o_tx_time), 32'h05);
        check("t1_src", 32'(bus.o_tx_src), 32'd0);
        tick();
        check("t1_valid_after", 32'(bus.o_tx_valid), 32'd0);
        check("t1_pending_after", 32'(o_pending), 32'd0);
        drain("t1", 50);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.i_tx_ready = 1'b1;
            i_req_pulse    = vecs[v].mask;
            i_req_time     = vecs[v].times;
            for (int j = 0; j < vecs[v].n; j++) begin
                logic [1:0] s;
                s = vecs[v].order[2*j +: 2];
                push(int'(s), vecs[v].times[8*s +: 8]);
            end
            tick();
            i_req_pulse = '0;
            check("vec_pending", 32'(o_pending), 32'(vecs[v].mask));
            drain("vec", 200);
        end

        // Back-pressure: offer held stable while not ready.
        do_reset();
        bus.i_tx_ready = 1'b0;
        i_req_pulse    = 4'b1000;
        i_req_time     = 32'h3C00_0000;
        push(3, 8'h3C);
        tick();
        i_req_pulse = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(bus.o_tx_valid), 32'd1);
            check("t3_hold_time", 32'(bus.o_tx_time), 32'h3C);
            check("t3_hold_src", 32'(bus.o_tx_src), 32'd3);
            tick();
        end
        bus.i_tx_ready = 1'b1;
        tick();
        check("t3_valid_after", 32'(bus.o_tx_valid), 32'd0);
        drain("t3", 50);

        // Overwrite of a pending, not-offered requester.
        do_reset();
        bus.i_tx_ready = 1'b0;
        i_req_pulse    = 4'b0001;
        i_req_time     = 32'h0000_0001;
        tick();
        i_req_pulse = 4'b0100;
        i_req_time  = 32'h0021_0000;
        tick();
        i_req_time  = 32'h0022_0000;
        tick();
        i_req_pulse = '0;
        check("t4_pending", 32'(o_pending), 32'h5);
        check("t4_offer_time", 32'(bus.o_tx_time), 32'h01);
`ifdef SPACE_WIRE_TICK_ARB_DROP_CNT_EN
        check("t4_drop_cnt", o_drop_cnt, 32'h0001_0000);
`endif
        push(0, 8'h01);
        push(2, 8'h22);
        bus.i_tx_ready = 1'b1;
        drain("t4", 100);
`ifdef SPACE_WIRE_TICK_ARB_DROP_CNT_EN
        i_drop_clr = 1'b1;
        tick();
        i_drop_clr = 1'b0;
        check("t4_drop_clr", o_drop_cnt, 32'd0);
`endif

        // Re-arm of the offered source before the transfer edge.
        do_reset();
        bus.i_tx_ready = 1'b0;
        i_req_pulse    = 4'b0010;
        i_req_time     = 32'h0000_3000;
        tick();
        i_req_pulse = '0;
        tick();
        i_req_pulse = 4'b0010;
        i_req_time  = 32'h0000_3100;
        tick();
        i_req_pulse = '0;
        check("t5_time_unchanged", 32'(bus.o_tx_time), 32'h30);
        push(1, 8'h30);
        push(1, 8'h31);
        bus.i_tx_ready = 1'b1;
        tick();
        check("t5_pending_kept", 32'(o_pending), 32'h2);
        check("t5_valid_after", 32'(bus.o_tx_valid), 32'd0);
        drain("t5", 100);
`ifdef SPACE_WIRE_TICK_ARB_DROP_CNT_EN
        check("t5_no_drop", o_drop_cnt, 32'd0);
`endif

        // Re-arm on the transfer edge itself.
        do_reset();
        bus.i_tx_ready = 1'b0;
        i_req_pulse    = 4'b0010;
        i_req_time     = 32'h0000_4000;
        tick();
        i_req_pulse = '0;
        tick();
        push(1, 8'h40);
        push(1, 8'h41);
        bus.i_tx_ready = 1'b1;
        i_req_pulse    = 4'b0010;
        i_req_time     = 32'h0000_4100;
        tick();
        i_req_pulse = '0;
        check("t5b_pending_kept", 32'(o_pending), 32'h2);
        drain("t5b", 100);

        // Reset during an offer.
        do_reset();
        bus.i_tx_ready = 1'b0;
        i_req_pulse    = 4'b0110;
        i_req_time     = 32'h0052_5100;
        tick();
        i_req_pulse = '0;
        tick();
        check("t6_offer_src", 32'(bus.o_tx_src), 32'd1);
        i_reset = 1'b1;
        tick();
        check("t6_valid_rst", 32'(bus.o_tx_valid), 32'd0);
        check("t6_pending_rst", 32'(o_pending), 32'd0);
        check("t6_busy_rst", 32'(o_busy), 32'd0);
        check("t6_src_rst", 32'(bus.o_tx_src), 32'd0);
        i_reset        = 1'b0;
        bus.i_tx_ready = 1'b1;
        i_req_pulse    = 4'b1001;
        i_req_time     = 32'h6300_0060;
        push(0, 8'h60);
        push(3, 8'h63);
        tick();
        i_req_pulse = '0;
        drain("t6", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
